// File: rtl/nonce_result_tx.sv
// rtl/nonce_result_tx.sv - golden nonce / work-ack return path to the MIPI TX pixel generator
// Queues nonces, coalesces acks into one MAGIC word and drives the send/busy handshake.
module nonce_result_tx #(
  parameter int unsigned DEPTH_LOG2  = 2,
  parameter logic [31:0] MAGIC       = 32'h79616B6F,
  parameter int unsigned REQ_TIMEOUT = 1024,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic                  hash_clk,
  input  logic                  rst_n,
  input  logic                  nonce_valid,
  input  logic [31:0]           nonce_in,
  input  logic                  work_ack,
  input  logic                  tx_busy,
  output logic                  send_data,
  output logic [31:0]           tx_data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  output logic [15:0]           sent_count
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned PW      = DEPTH_LOG2 + 1;
  localparam int unsigned TMAX    = (REQ_TIMEOUT > GAP_CYCLES) ? REQ_TIMEOUT : GAP_CYCLES;
  localparam int unsigned TIMER_W = $clog2(TMAX) + 1;
  localparam logic [TIMER_W-1:0] REQ_LAST = TIMER_W'(REQ_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DONE, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 retry_q, retry_d;
  logic                 send_q, send_d;
  logic [31:0]          tx_data_q, tx_data_d;
  logic [15:0]          sent_q, sent_d;
  logic                 ack_pending_q, ack_pending_d;
  logic                 busy_meta_q, busy_meta_d;
  logic                 busy_s_q, busy_s_d;
  logic [31:0]          mem_q [DEPTH];
  logic [31:0]          mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_q, drop_d;

  logic empty, full, push, pop, drop, ack_load;

  // Extra pointer bit: equal pointers mean empty, differing only in the MSB means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    send_d      = send_q;
    tx_data_d   = tx_data_q;
    sent_d      = sent_q;
    pop         = 1'b0;
    ack_load    = 1'b0;
    busy_meta_d = tx_busy;
    busy_s_d    = busy_meta_q;

    case (state_q)
      S_IDLE: begin
        if (ack_pending_q) begin
          ack_load  = 1'b1;
          tx_data_d = MAGIC;
          send_d    = 1'b1;
          timer_d   = '0;
          state_d   = S_REQ;
        end else if (!empty) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          send_d    = 1'b1;
          timer_d   = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (busy_s_q) begin
          send_d  = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (timer_q == REQ_LAST) begin
          send_d  = 1'b0;
          retry_d = 1'b1;
          timer_d = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!busy_s_q) begin
          sent_d  = sent_q + 16'd1;
          retry_d = 1'b0;
          timer_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          // A timed-out word is re-requested as-is; tx_data was never reloaded.
          if (retry_q) begin
            send_d  = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    push = nonce_valid && (!full || pop);
    drop = nonce_valid && !push;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = nonce_in;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = wr_ptr_d - rd_ptr_d;

    overflow_d = overflow_q | drop;
    drop_d     = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    // A new ack arriving as the old one is loaded must survive as a fresh request.
    ack_pending_d = (ack_pending_q && !ack_load) || work_ack;
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      retry_q       <= 1'b0;
      send_q        <= 1'b0;
      tx_data_q     <= '0;
      sent_q        <= '0;
      ack_pending_q <= 1'b0;
      busy_meta_q   <= 1'b0;
      busy_s_q      <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      send_q        <= send_d;
      tx_data_q     <= tx_data_d;
      sent_q        <= sent_d;
      ack_pending_q <= ack_pending_d;
      busy_meta_q   <= busy_meta_d;
      busy_s_q      <= busy_s_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      drop_q        <= drop_d;
    end
  end

  assign send_data  = send_q;
  assign tx_data    = tx_data_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_nonce_result_tx.sv
// tb/tb_nonce_result_tx.sv - table-driven, directed and randomized checks of nonce_result_tx
module tb_nonce_result_tx;

  localparam logic [31:0] MAGIC = 32'h79616B6F;

  logic        hash_clk = 1'b0;
  logic        rst_n;
  logic        nonce_valid;
  logic [31:0] nonce_in;
  logic        work_ack;
  logic        tx_busy;
  logic        send_data;
  logic [31:0] tx_data;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [15:0] sent_count;

  int total = 0;
  int bad   = 0;

  always #5 hash_clk = ~hash_clk;

  nonce_result_tx dut (
    .hash_clk   (hash_clk),
    .rst_n      (rst_n),
    .nonce_valid(nonce_valid),
    .nonce_in   (nonce_in),
    .work_ack   (work_ack),
    .tx_busy    (tx_busy),
    .send_data  (send_data),
    .tx_data    (tx_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .sent_count (sent_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: nonce queue capped at 4, one ack flag, sticky drop stats.
  logic [31:0] mq[$];
  logic [31:0] seen[$];
  logic        m_ack, m_ovf;
  int          m_drop, acc_cnt;
  logic        need_retry, prev_send, prev_bs;
  logic [31:0] prev_tx, last_word, m_exp;
  logic        cap_nv, cap_ack, bs1, bs2;
  logic [31:0] cap_n;

  always @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_nv <= 1'b0; cap_ack <= 1'b0; cap_n <= '0; bs1 <= 1'b0; bs2 <= 1'b0;
    end else begin
      cap_nv <= nonce_valid; cap_ack <= work_ack; cap_n <= nonce_in;
      bs1 <= tx_busy; bs2 <= bs1;
    end
  end

  always @(negedge hash_clk) begin
    if (!rst_n) begin
      mq.delete();
      m_ack = 1'b0; m_ovf = 1'b0; m_drop = 0; acc_cnt = 0;
      need_retry = 1'b0; prev_send = 1'b0; prev_bs = 1'b0; prev_tx = '0; last_word = '0;
    end else begin
      if (prev_send && send_data) check("tx_data stable", tx_data, prev_tx);
      if (prev_send && !send_data) begin
        if (prev_bs) acc_cnt++;
        else need_retry = 1'b1;
      end
      if (!prev_send && send_data) begin
        if (need_retry) begin
          check("retry word", tx_data, last_word);
          need_retry = 1'b0;
        end else if (m_ack || mq.size() > 0) begin
          if (m_ack) begin
            m_exp = MAGIC;
            m_ack = 1'b0;
          end else begin
            m_exp = mq.pop_front();
          end
          check("loaded word", tx_data, m_exp);
          seen.push_back(tx_data);
          last_word = tx_data;
        end else begin
          total++; bad++;
          $display("FAIL unexpected load: got %h want none", tx_data);
        end
      end
      if (cap_ack) m_ack = 1'b1;
      if (cap_nv) begin
        if (mq.size() < 4) mq.push_back(cap_n);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      check("fifo_level", 32'(fifo_level), 32'(mq.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      prev_send = send_data;
      prev_tx   = tx_data;
      prev_bs   = bs2;
    end
  end

  // Busy responder standing in for mipi_tx.
  logic auto_resp = 1'b1;
  logic rand_resp = 1'b0;

  initial begin
    int d, h, n;
    forever begin
      @(negedge hash_clk);
      if (auto_resp && send_data && rst_n) begin
        d = rand_resp ? int'($urandom_range(0, 6)) : 5;
        h = rand_resp ? int'($urandom_range(1, 8)) : 20;
        repeat (d) @(negedge hash_clk);
        tx_busy = 1'b1;
        repeat (h) @(negedge hash_clk);
        tx_busy = 1'b0;
        n = 0;
        while (send_data && n < 50) begin
          @(negedge hash_clk);
          n++;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic nv, input logic [31:0] n, input logic ack);
    nonce_valid = nv; nonce_in = n; work_ack = ack;
    @(negedge hash_clk);
    nonce_valid = 1'b0; work_ack = 1'b0;
  endtask

  function automatic logic [31:0] seen_at(input int i);
    if (i < seen.size()) return seen[i];
    return 32'hFFFF_FFFF ^ 32'h5A5A_5A5A;
  endfunction

  typedef struct {
    logic        nv;
    logic [31:0] n;
    logic        ack;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t        vecs[5];
  int          exp_sent;
  int          cnt;
  logic [31:0] ovf_exp[5];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0001, 1'b1, 2, MAGIC, 32'h0000_0001};
    vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 1, MAGIC, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0000, 1'b0, 1, 32'h0000_0000, 32'h0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 2, MAGIC, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 32'h1234_5678, 1'b0, 1, 32'h1234_5678, 32'h0};
    ovf_exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};

    rst_n = 1'b0; nonce_valid = 1'b0; nonce_in = '0; work_ack = 1'b0; tx_busy = 1'b0;
    exp_sent = 0;
    repeat (3) @(negedge hash_clk);
    check("reset send_data", 32'(send_data), 32'd0);
    check("reset tx_data", tx_data, 32'd0);
    check("reset fifo_level", 32'(fifo_level), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset drop_count", 32'(drop_count), 32'd0);
    check("reset sent_count", 32'(sent_count), 32'd0);
    rst_n = 1'b1;
    @(negedge hash_clk);

    // Single nonce with latency check.
    seen.delete();
    pulse(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("latency push cycle", 32'(send_data), 32'd0);
    @(negedge hash_clk);
    check("latency request", 32'(send_data), 32'd1);
    check("single tx_data", tx_data, 32'hDEAD_BEEF);
    repeat (100) @(negedge hash_clk);
    exp_sent += 1;
    check("single words", 32'(seen.size()), 32'd1);
    check("single sent_count", 32'(sent_count), 32'(exp_sent));
    check("single level", 32'(fifo_level), 32'd0);

    // Table: strobes applied together while idle.
    for (int i = 0; i < 5; i++) begin
      seen.delete();
      pulse(vecs[i].nv, vecs[i].n, vecs[i].ack);
      repeat (150) @(negedge hash_clk);
      exp_sent += vecs[i].nwords;
      check($sformatf("vec%0d words", i), 32'(seen.size()), 32'(vecs[i].nwords));
      check($sformatf("vec%0d w0", i), seen_at(0), vecs[i].w0);
      if (vecs[i].nwords == 2) check($sformatf("vec%0d w1", i), seen_at(1), vecs[i].w1);
      check($sformatf("vec%0d sent_count", i), 32'(sent_count), 32'(exp_sent));
    end

    // Ack coalescing during one busy word.
    seen.delete();
    pulse(1'b1, 32'h0BAD_F00D, 1'b0);
    cnt = 0;
    while (!tx_busy && cnt < 100) begin
      @(negedge hash_clk);
      cnt++;
    end
    check("coalesce busy seen", 32'(tx_busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 32'h0, 1'b1);
      @(negedge hash_clk);
    end
    repeat (200) @(negedge hash_clk);
    exp_sent += 2;
    check("coalesce words", 32'(seen.size()), 32'd2);
    check("coalesce w0", seen_at(0), 32'h0BAD_F00D);
    check("coalesce w1", seen_at(1), MAGIC);
    check("coalesce sent_count", 32'(sent_count), 32'(exp_sent));

    // Overflow with busy held high, then drop_count saturation.
    auto_resp = 1'b0;
    tx_busy = 1'b1;
    repeat (4) @(negedge hash_clk);
    seen.delete();
    for (int k = 1; k <= 6; k++) pulse(1'b1, 32'(k), 1'b0);
    check("ovf overflow", 32'(overflow), 32'd1);
    check("ovf drop_count", 32'(drop_count), 32'd1);
    check("ovf level", 32'(fifo_level), 32'd4);
    for (int k = 0; k < 300; k++) pulse(1'b1, $urandom, 1'b0);
    check("ovf drop saturate", 32'(drop_count), 32'd255);
    tx_busy = 1'b0;
    auto_resp = 1'b1;
    repeat (400) @(negedge hash_clk);
    exp_sent += 5;
    check("ovf words", 32'(seen.size()), 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("ovf order %0d", k), seen_at(k), ovf_exp[k]);
    check("ovf sent_count", 32'(sent_count), 32'(exp_sent));

    // Request timeout and identical retry.
    auto_resp = 1'b0;
    seen.delete();
    pulse(1'b1, 32'hCAFE_F00D, 1'b0);
    cnt = 0;
    while (!send_data && cnt < 20) begin
      @(negedge hash_clk);
      cnt++;
    end
    check("timeout request", 32'(send_data), 32'd1);
    cnt = 0;
    while (send_data && cnt < 1100) begin
      cnt++;
      @(negedge hash_clk);
    end
    check("timeout high cycles", 32'(cnt), 32'd1024);
    cnt = 0;
    while (!send_data && cnt < 100) begin
      cnt++;
      @(negedge hash_clk);
    end
    check("timeout gap cycles", 32'(cnt), 32'd16);
    check("retry send_data", 32'(send_data), 32'd1);
    check("retry tx_data", tx_data, 32'hCAFE_F00D);
    check("retry sent_count", 32'(sent_count), 32'(exp_sent));
    auto_resp = 1'b1;
    repeat (100) @(negedge hash_clk);
    exp_sent += 1;
    check("retry sent_count after", 32'(sent_count), 32'(exp_sent));
    check("retry single load", 32'(seen.size()), 32'd1);

    // Asynchronous reset in WAIT_DONE with two nonces queued.
    auto_resp = 1'b0;
    tx_busy = 1'b1;
    repeat (3) @(negedge hash_clk);
    pulse(1'b1, 32'd11, 1'b0);
    pulse(1'b1, 32'd12, 1'b0);
    pulse(1'b1, 32'd13, 1'b0);
    repeat (5) @(negedge hash_clk);
    check("pre-reset level", 32'(fifo_level), 32'd2);
    #2;
    rst_n = 1'b0;
    tx_busy = 1'b0;
    #1;
    check("async send_data", 32'(send_data), 32'd0);
    check("async fifo_level", 32'(fifo_level), 32'd0);
    check("async overflow", 32'(overflow), 32'd0);
    check("async sent_count", 32'(sent_count), 32'd0);
    check("async drop_count", 32'(drop_count), 32'd0);
    check("async tx_data", tx_data, 32'd0);
    @(negedge hash_clk);
    seen.delete();
    #2;
    rst_n = 1'b1;
    exp_sent = 0;
    auto_resp = 1'b1;
    repeat (100) @(negedge hash_clk);
    check("post-reset words", 32'(seen.size()), 32'd0);
    check("post-reset sent_count", 32'(sent_count), 32'(exp_sent));

    // Randomized traffic against the model.
    rand_resp = 1'b1;
    for (int k = 0; k < 400; k++) begin
      nonce_valid = ($urandom_range(0, 9) == 0);
      work_ack    = ($urandom_range(0, 19) == 0);
      nonce_in    = $urandom;
      @(negedge hash_clk);
    end
    nonce_valid = 1'b0;
    work_ack = 1'b0;
    repeat (600) @(negedge hash_clk);
    check("random drained queue", 32'(mq.size()), 32'd0);
    check("random drained ack", 32'(m_ack), 32'd0);
    check("random sent_count", 32'(sent_count), 32'(acc_cnt[15:0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
